// File: rtl/ahblite_slave_mux.sv
// AHB-Lite slave multiplexor with integrated default slave.
// Registers the decoder selects in the address phase and routes the selected
// slave's response in the data phase. Unmapped active transfers get a
// two-cycle ERROR from the built-in default slave, which also keeps diagnostics.
//
// Default-slave states:
//   state    | meaning
//   ST_IDLE  | no error in progress, OKAY zero-wait
//   ST_ERR1  | first ERROR cycle (HREADYOUT=0, HRESP=1)
//   ST_ERR2  | second ERROR cycle (HREADYOUT=1, HRESP=1)
module ahblite_slave_mux (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        P0_EN,
    input  logic        P1_EN,
    input  logic        P2_EN,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HREADY,
    input  logic        P0_HSEL,
    input  logic        P1_HSEL,
    input  logic        P2_HSEL,
    input  logic        P0_HREADYOUT,
    input  logic        P1_HREADYOUT,
    input  logic        P2_HREADYOUT,
    input  logic        P0_HRESP,
    input  logic        P1_HRESP,
    input  logic        P2_HRESP,
    input  logic [31:0] P0_HRDATA,
    input  logic [31:0] P1_HRDATA,
    input  logic [31:0] P2_HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA,
    output logic [31:0] ERR_ADDR,
    output logic [7:0]  ERR_COUNT
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } ds_state_t;

    // One-hot data-phase select {DEF,P2,P1,P0}; all-zero is NONE (reset only).
    localparam logic [3:0] SEL_NONE = 4'b0000;
    localparam logic [3:0] SEL_P0   = 4'b0001;
    localparam logic [3:0] SEL_P1   = 4'b0010;
    localparam logic [3:0] SEL_P2   = 4'b0100;
    localparam logic [3:0] SEL_DEF  = 4'b1000;

    logic [2:0]  en_sel;
    logic [3:0]  addr_sel;
    logic        addr_def;
    logic        err_start;
    logic [3:0]  sel_d, sel_q;
    ds_state_t   state_d, state_q;
    logic [31:0] err_addr_d, err_addr_q;
    logic [7:0]  err_count_d, err_count_q;
    logic        def_hreadyout;
    logic        def_hresp;

    assign en_sel    = {P2_HSEL & P2_EN, P1_HSEL & P1_EN, P0_HSEL & P0_EN};
    assign addr_def  = (en_sel == 3'b000);
    assign err_start = HREADY & addr_def & HTRANS[1];

    // Address-phase decode with fixed priority P0 > P1 > P2; select held during waits.
    always_comb begin
        addr_sel = SEL_DEF;
        if (en_sel[0])      addr_sel = SEL_P0;
        else if (en_sel[1]) addr_sel = SEL_P1;
        else if (en_sel[2]) addr_sel = SEL_P2;
        sel_d = HREADY ? addr_sel : sel_q;
    end

    // Default-slave next state and its response outputs.
    always_comb begin
        state_d       = state_q;
        def_hreadyout = 1'b1;
        def_hresp     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (err_start) state_d = ST_ERR1;
            end
            ST_ERR1: begin
                def_hreadyout = 1'b0;
                def_hresp     = 1'b1;
                state_d       = ST_ERR2;
            end
            ST_ERR2: begin
                def_hreadyout = 1'b1;
                def_hresp     = 1'b1;
                state_d       = err_start ? ST_ERR1 : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Diagnostics: capture the faulting address on entry to ERR1, count completed errors.
    always_comb begin
        err_addr_d  = err_addr_q;
        err_count_d = err_count_q;
        if (err_start && (state_q != ST_ERR1)) err_addr_d = HADDR;
        if ((state_q == ST_ERR2) && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            sel_q       <= SEL_NONE;
            state_q     <= ST_IDLE;
            err_addr_q  <= 32'h0;
            err_count_q <= 8'h0;
        end else begin
            sel_q       <= sel_d;
            state_q     <= state_d;
            err_addr_q  <= err_addr_d;
            err_count_q <= err_count_d;
        end
    end

    // Data-phase response mux, combinational from sel_q.
    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        HRDATA    = 32'h0;
        case (sel_q)
            SEL_P0: begin
                HREADYOUT = P0_HREADYOUT;
                HRESP     = P0_HRESP;
                HRDATA    = P0_HRDATA;
            end
            SEL_P1: begin
                HREADYOUT = P1_HREADYOUT;
                HRESP     = P1_HRESP;
                HRDATA    = P1_HRDATA;
            end
            SEL_P2: begin
                HREADYOUT = P2_HREADYOUT;
                HRESP     = P2_HRESP;
                HRDATA    = P2_HRDATA;
            end
            SEL_DEF: begin
                HREADYOUT = def_hreadyout;
                HRESP     = def_hresp;
            end
            default: begin
                HREADYOUT = 1'b1;
                HRESP     = 1'b0;
                HRDATA    = 32'h0;
            end
        endcase
    end

    assign ERR_ADDR  = err_addr_q;
    assign ERR_COUNT = err_count_q;

endmodule

// File: tb/tb_ahblite_slave_mux.sv
// Bench for ahblite_slave_mux: directed vector table, hand-written corner
// sequences and randomized traffic, all checked against a behavioural model.
module tb_ahblite_slave_mux;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HREADY;
    logic [2:0]  en, hsel, prdy, presp;
    logic [31:0] prdata [3];
    logic        HREADYOUT, HRESP;
    logic [31:0] HRDATA, ERR_ADDR;
    logic [7:0]  ERR_COUNT;

    always #5 HCLK = ~HCLK;

    assign HREADY = HREADYOUT;

    ahblite_slave_mux dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .P0_EN(en[0]), .P1_EN(en[1]), .P2_EN(en[2]),
        .HADDR(HADDR), .HTRANS(HTRANS), .HREADY(HREADY),
        .P0_HSEL(hsel[0]), .P1_HSEL(hsel[1]), .P2_HSEL(hsel[2]),
        .P0_HREADYOUT(prdy[0]), .P1_HREADYOUT(prdy[1]), .P2_HREADYOUT(prdy[2]),
        .P0_HRESP(presp[0]), .P1_HRESP(presp[1]), .P2_HRESP(presp[2]),
        .P0_HRDATA(prdata[0]), .P1_HRDATA(prdata[1]), .P2_HRDATA(prdata[2]),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
        .ERR_ADDR(ERR_ADDR), .ERR_COUNT(ERR_COUNT)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: which slave owns the data phase (-1 none, 0..2 port,
    // 3 default slave) and how many ERROR cycles remain to be shown.
    int          m_sel;
    int          m_left;
    logic [31:0] m_ea;
    int          m_cnt;

    task automatic m_out(output logic r, output logic s, output logic [31:0] d);
        r = 1'b1; s = 1'b0; d = 32'h0;
        if (m_sel >= 0 && m_sel <= 2) begin
            r = prdy[m_sel]; s = presp[m_sel]; d = prdata[m_sel];
        end else if (m_sel == 3) begin
            r = (m_left != 2);
            s = (m_left != 0);
        end
    endtask

    task automatic m_update();
        logic r, s;
        logic [31:0] d;
        int dsel;
        if (HRESET) begin
            m_sel = -1; m_left = 0; m_ea = 32'h0; m_cnt = 0;
            return;
        end
        m_out(r, s, d);
        dsel = 3;
        for (int i = 2; i >= 0; i--) if (hsel[i] && en[i]) dsel = i;
        if (m_left == 1 && m_cnt < 255) m_cnt++;
        if (r && dsel == 3 && HTRANS[1]) begin
            m_left = 2;
            m_ea   = HADDR;
        end else if (m_left > 0) begin
            m_left--;
        end
        if (r) m_sel = dsel;
    endtask

    task automatic half_check(input bit do_chk);
        logic r, s;
        logic [31:0] d;
        @(negedge HCLK);
        #1;
        if (do_chk) begin
            m_out(r, s, d);
            chk("model_hreadyout", {31'h0, HREADYOUT}, {31'h0, r});
            chk("model_hresp", {31'h0, HRESP}, {31'h0, s});
            chk("model_hrdata", HRDATA, d);
            chk("model_err_addr", ERR_ADDR, m_ea);
            chk("model_err_count", {24'h0, ERR_COUNT}, m_cnt);
        end
    endtask

    task automatic edge_update();
        @(posedge HCLK);
        m_update();
        #1;
    endtask

    task automatic tick(input bit do_chk);
        half_check(do_chk);
        edge_update();
    endtask

    task automatic idle_bus();
        HTRANS = 2'b00; hsel = 3'b000; HADDR = 32'h0;
    endtask

    typedef struct {
        logic [2:0]  en, hsel;
        logic [1:0]  tr;
        logic [31:0] addr;
        logic [2:0]  rdy, resp;
        logic        e_rdy, e_resp;
        logic [31:0] e_data;
        logic [7:0]  e_cnt;
        logic [31:0] e_ea;
    } vec_t;

    function automatic vec_t mk(logic [2:0] e, logic [2:0] hs, logic [1:0] tr, logic [31:0] a,
                                logic [2:0] rd, logic [2:0] rs, logic er, logic es,
                                logic [31:0] ed, logic [7:0] ec, logic [31:0] ea);
        vec_t v;
        v.en = e; v.hsel = hs; v.tr = tr; v.addr = a; v.rdy = rd; v.resp = rs;
        v.e_rdy = er; v.e_resp = es; v.e_data = ed; v.e_cnt = ec; v.e_ea = ea;
        return v;
    endfunction

    vec_t tbl [31];

    initial begin
        // idle bus after reset, then P1 read with two wait states and a P0 address queued
        tbl[0]  = mk(3'b111, 3'b000, 2'b00, 32'h0,         3'b111, 3'b000, 1, 0, 32'h0,         8'd0, 32'h0);
        tbl[1]  = mk(3'b111, 3'b000, 2'b00, 32'h0,         3'b111, 3'b000, 1, 0, 32'h0,         8'd0, 32'h0);
        tbl[2]  = mk(3'b111, 3'b010, 2'b10, 32'h2000_0010, 3'b101, 3'b000, 1, 0, 32'h0,         8'd0, 32'h0);
        tbl[3]  = mk(3'b111, 3'b000, 2'b00, 32'h0,         3'b101, 3'b000, 0, 0, 32'h1234_5678, 8'd0, 32'h0);
        tbl[4]  = mk(3'b111, 3'b001, 2'b10, 32'h0000_0020, 3'b101, 3'b000, 0, 0, 32'h1234_5678, 8'd0, 32'h0);
        tbl[5]  = mk(3'b111, 3'b001, 2'b10, 32'h0000_0020, 3'b111, 3'b000, 1, 0, 32'h1234_5678, 8'd0, 32'h0);
        tbl[6]  = mk(3'b111, 3'b000, 2'b00, 32'h0,         3'b111, 3'b000, 1, 0, 32'hA0A0_A0A0, 8'd0, 32'h0);
        // single unmapped NONSEQ
        tbl[7]  = mk(3'b111, 3'b000, 2'b10, 32'h6000_0004, 3'b111, 3'b000, 1, 0, 32'h0,         8'd0, 32'h0);
        tbl[8]  = mk(3'b111, 3'b000, 2'b00, 32'h0,         3'b111, 3'b000, 0, 1, 32'h0,         8'd0, 32'h6000_0004);
        tbl[9]  = mk(3'b111, 3'b000, 2'b00, 32'h0,         3'b111, 3'b000, 1, 1, 32'h0,         8'd0, 32'h6000_0004);
        tbl[10] = mk(3'b111, 3'b000, 2'b00, 32'h0,         3'b111, 3'b000, 1, 0, 32'h0,         8'd1, 32'h6000_0004);
        // disabled port 2 is treated as unmapped; its data never reaches HRDATA
        tbl[11] = mk(3'b011, 3'b100, 2'b10, 32'h4000_0008, 3'b111, 3'b000, 1, 0, 32'h0,         8'd1, 32'h6000_0004);
        tbl[12] = mk(3'b011, 3'b000, 2'b00, 32'h0,         3'b111, 3'b000, 0, 1, 32'h0,         8'd1, 32'h4000_0008);
        tbl[13] = mk(3'b011, 3'b000, 2'b00, 32'h0,         3'b111, 3'b000, 1, 1, 32'h0,         8'd1, 32'h4000_0008);
        tbl[14] = mk(3'b111, 3'b000, 2'b00, 32'h0,         3'b111, 3'b000, 1, 0, 32'h0,         8'd2, 32'h4000_0008);
        // enabled port 2 slave ERROR passes through untouched
        tbl[15] = mk(3'b111, 3'b100, 2'b10, 32'h4000_0008, 3'b111, 3'b000, 1, 0, 32'h0,         8'd2, 32'h4000_0008);
        tbl[16] = mk(3'b111, 3'b000, 2'b00, 32'h0,         3'b011, 3'b100, 0, 1, 32'hDEAD_BEEF, 8'd2, 32'h4000_0008);
        tbl[17] = mk(3'b111, 3'b000, 2'b00, 32'h0,         3'b111, 3'b100, 1, 1, 32'hDEAD_BEEF, 8'd2, 32'h4000_0008);
        tbl[18] = mk(3'b111, 3'b000, 2'b00, 32'h0,         3'b111, 3'b000, 1, 0, 32'h0,         8'd2, 32'h4000_0008);
        // unmapped transfer cancelled by master during ERR1
        tbl[19] = mk(3'b111, 3'b000, 2'b10, 32'h7000_0000, 3'b111, 3'b000, 1, 0, 32'h0,         8'd2, 32'h4000_0008);
        tbl[20] = mk(3'b111, 3'b000, 2'b00, 32'h0,         3'b111, 3'b000, 0, 1, 32'h0,         8'd2, 32'h7000_0000);
        tbl[21] = mk(3'b111, 3'b000, 2'b00, 32'h0,         3'b111, 3'b000, 1, 1, 32'h0,         8'd2, 32'h7000_0000);
        tbl[22] = mk(3'b111, 3'b000, 2'b00, 32'h0,         3'b111, 3'b000, 1, 0, 32'h0,         8'd3, 32'h7000_0000);
        // three back-to-back unmapped NONSEQs
        tbl[23] = mk(3'b111, 3'b000, 2'b10, 32'h8000_0000, 3'b111, 3'b000, 1, 0, 32'h0,         8'd3, 32'h7000_0000);
        tbl[24] = mk(3'b111, 3'b000, 2'b10, 32'h8000_0004, 3'b111, 3'b000, 0, 1, 32'h0,         8'd3, 32'h8000_0000);
        tbl[25] = mk(3'b111, 3'b000, 2'b10, 32'h8000_0004, 3'b111, 3'b000, 1, 1, 32'h0,         8'd3, 32'h8000_0000);
        tbl[26] = mk(3'b111, 3'b000, 2'b10, 32'h8000_0008, 3'b111, 3'b000, 0, 1, 32'h0,         8'd4, 32'h8000_0004);
        tbl[27] = mk(3'b111, 3'b000, 2'b10, 32'h8000_0008, 3'b111, 3'b000, 1, 1, 32'h0,         8'd4, 32'h8000_0004);
        tbl[28] = mk(3'b111, 3'b000, 2'b00, 32'h0,         3'b111, 3'b000, 0, 1, 32'h0,         8'd5, 32'h8000_0008);
        tbl[29] = mk(3'b111, 3'b000, 2'b00, 32'h0,         3'b111, 3'b000, 1, 1, 32'h0,         8'd5, 32'h8000_0008);
        tbl[30] = mk(3'b111, 3'b000, 2'b00, 32'h0,         3'b111, 3'b000, 1, 0, 32'h0,         8'd6, 32'h8000_0008);

        m_sel = -1; m_left = 0; m_ea = 32'h0; m_cnt = 0;
        HRESET = 1'b1; en = 3'b111; prdy = 3'b111; presp = 3'b000;
        prdata[0] = 32'hA0A0_A0A0; prdata[1] = 32'h1234_5678; prdata[2] = 32'hDEAD_BEEF;
        idle_bus();
        tick(0);
        tick(0);
        HRESET = 1'b0;

        // directed vector table
        for (int i = 0; i < 31; i++) begin
            en = tbl[i].en; hsel = tbl[i].hsel; HTRANS = tbl[i].tr; HADDR = tbl[i].addr;
            prdy = tbl[i].rdy; presp = tbl[i].resp;
            half_check(1);
            chk($sformatf("tbl%0d_hreadyout", i), {31'h0, HREADYOUT}, {31'h0, tbl[i].e_rdy});
            chk($sformatf("tbl%0d_hresp", i), {31'h0, HRESP}, {31'h0, tbl[i].e_resp});
            chk($sformatf("tbl%0d_hrdata", i), HRDATA, tbl[i].e_data);
            chk($sformatf("tbl%0d_err_count", i), {24'h0, ERR_COUNT}, {24'h0, tbl[i].e_cnt});
            chk($sformatf("tbl%0d_err_addr", i), ERR_ADDR, tbl[i].e_ea);
            edge_update();
        end

        // saturation: continuous unmapped NONSEQs well past 255 errors
        en = 3'b111; prdy = 3'b111; presp = 3'b000;
        hsel = 3'b000; HTRANS = 2'b10; HADDR = 32'h9000_0000;
        for (int i = 0; i < 520; i++) tick(1);
        idle_bus();
        for (int i = 0; i < 4; i++) tick(1);
        half_check(0);
        chk("sat_err_count", {24'h0, ERR_COUNT}, 32'hFF);
        chk("sat_hresp_idle", {31'h0, HRESP}, 32'h0);
        edge_update();

        // reset asserted during ERR1
        hsel = 3'b000; HTRANS = 2'b10; HADDR = 32'hB000_0000;
        tick(1);
        idle_bus();
        HRESET = 1'b1;
        half_check(0);
        chk("err1_before_rst_hreadyout", {31'h0, HREADYOUT}, 32'h0);
        chk("err1_before_rst_hresp", {31'h0, HRESP}, 32'h1);
        edge_update();
        HRESET = 1'b0;
        half_check(1);
        chk("rst_hreadyout", {31'h0, HREADYOUT}, 32'h1);
        chk("rst_hresp", {31'h0, HRESP}, 32'h0);
        chk("rst_hrdata", HRDATA, 32'h0);
        chk("rst_err_count", {24'h0, ERR_COUNT}, 32'h0);
        chk("rst_err_addr", ERR_ADDR, 32'h0);
        edge_update();
        tick(1);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            HRESET = ($urandom_range(0, 99) == 0);
            en     = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111;
            hsel   = ($urandom_range(0, 2) == 0) ? 3'b000 : 3'($urandom);
            HTRANS = 2'($urandom);
            HADDR  = $urandom;
            for (int p = 0; p < 3; p++) begin
                prdy[p]   = ($urandom_range(0, 3) != 0);
                presp[p]  = ($urandom_range(0, 7) == 0);
                prdata[p] = $urandom;
            end
            tick(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
